bcd_to_bin_converter: RTL
=========================

// Module: bcd_to_bin_converter
// PURPOSE
//  Sequential BCD-to-binary decoder (reverse double dabble): inverse of the display-path binary-to-BCD converter.
//  Takes a packed BCD word (e.g. digits keyed in or read back from the display buffer) and returns its binary value.
//  Runs on the refresh-clock domain alongside the MRU; one conversion at a time, busy/rdy handshake.
// PARAMETERS
//  DIGITS     6   number of BCD digits; input width = 4*DIGITS
//  BIN_WIDTH  20  binary result width; must satisfy 10**DIGITS <= 2**BIN_WIDTH (elaboration error otherwise)
// PORTS
//  clk     in   1            single clock; all state on rising edge
//  rst_n   in   1            asynchronous, active-low reset
//  en      in   1            start request, sampled only in IDLE
//  data_i  in   4*DIGITS     packed BCD, digit0 = data_i[3:0]
//  data_o  out  BIN_WIDTH    binary result, held until next completion
//  busy_o  out  1            conversion in progress
//  rdy_o   out  1            one-cycle pulse: data_o/err_o just updated
//  err_o   out  1            valid with rdy_o: input had a nibble > 9
// BEHAVIOUR
//  Reset (async): state=IDLE, data_o=0, busy_o=0, rdy_o=0, err_o=0, shift reg=0, cnt=0.
//  FSM IDLE -> SHIFT -> DONE -> IDLE.
//  IDLE: edge with en=1 loads sr={data_i, BIN_WIDTH'b0}, cnt=0, busy_o<=1, -> SHIFT. en=0: stay.
//  SHIFT: each edge sr <= corr(sr>>1); corr: every BCD nibble of upper part >= 8 gets -3 (4-bit, no borrow).
//   cnt increments; after the BIN_WIDTH-th shift -> DONE.
//  DONE: data_o <= sr[BIN_WIDTH-1:0], rdy_o <= 1 (one cycle), busy_o <= 0, -> IDLE.
//  Latency: en sampled at edge E -> rdy_o high after edge E+BIN_WIDTH+1 (21 cycles for defaults), busy_o high
//   for edges E+1..E+BIN_WIDTH+1 window (cleared at the DONE edge).
//  Back-to-back: en high while rdy_o is high is accepted (FSM already IDLE).
//  en while busy: ignored, no queueing; data_i only sampled at start.
//  Reset mid-conversion: aborts immediately, outputs return to reset values, no rdy_o pulse.
//  Upper BCD part of sr is all-zero after the last shift for valid input (bench assertion).
//  Max value 10**DIGITS-1 fits BIN_WIDTH exactly; no overflow path.
// CONFIGURATION
//  BCD2BIN_DIGIT_CHECK_EN defined: at start any data_i nibble > 9 sets error flag; conversion still runs
//   for identical timing, but at DONE data_o <= 0 and err_o <= 1 with rdy_o. err_o cleared on next DONE
//   with valid input. Valid input: err_o=0.
//  Undefined: err_o tied 0; invalid nibbles pass through the algorithm, data_o unspecified (not checked).
// STRUCTURE
//  Shared package bcd_pkg: DIGIT_W=4, CORR_THRESH=4'd8, CORR_SUB=4'd3, state encoding (IDLE/SHIFT/DONE),
//   shared with the binary-to-BCD converter (which uses threshold 5, add 3).
//  One sub-module bcd_digit_corr: 4-bit nibble in -> (n>=8 ? n-3 : n) out; instantiated DIGITS times via generate.
//  Top holds FSM, shift-count counter (width $clog2(BIN_WIDTH+1)), sr of 4*DIGITS+BIN_WIDTH bits.
// TESTING
//  data_i=24'h999999, en pulse -> after 21 cycles rdy_o=1 for 1 cycle, data_o=20'hF423F, err_o=0.
//  data_i=24'h123456 -> data_o=20'h1E240; then 24'h000000 -> data_o=0, rdy_o still pulses.
//  Start 24'h000042, hold en high with data_i=24'h777777 during busy -> single result 20'h0002A, then
//   next conversion starts in rdy_o cycle and yields 20'hBDE31.
//  rst_n low at shift 10 -> busy_o/rdy_o/data_o=0 at once; release, new start converts normally.
//  With BCD2BIN_DIGIT_CHECK_EN: data_i=24'h00A000 -> rdy_o after 21 cycles, err_o=1, data_o=0; without: err_o=0.
//  Random sweep 0..999999 vs reference model, latency and one-pulse rdy_o checked each time.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD <-> binary converters: digit width, nibble
// correction constants and the common IDLE/SHIFT/DONE state encoding.
package bcd_pkg;

    localparam int DIGIT_W = 4;

    // Reverse double dabble uses (>= 8, -3); the forward converter uses (>= 5, +3).
    localparam logic [DIGIT_W-1:0] CORR_THRESH = 4'd8;
    localparam logic [DIGIT_W-1:0] CORR_SUB    = 4'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_e;

    function automatic logic nibble_is_bcd(input logic [DIGIT_W-1:0] nib);
        return nib <= 4'd9;
    endfunction

endpackage

// File: rtl/bcd_digit_corr.sv
// One BCD nibble correction step of the reverse double dabble:
// after a right shift, any nibble >= 8 has 3 subtracted (4-bit, no borrow).
module bcd_digit_corr
    import bcd_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);

    assign nib_o = (nib_i >= CORR_THRESH) ? (nib_i - CORR_SUB) : nib_i;

endmodule

// File: rtl/bcd_to_bin_converter.sv
// Sequential BCD-to-binary converter (reverse double dabble), busy/rdy handshake.
// Optional input digit check enabled by defining BCD2BIN_DIGIT_CHECK_EN.
module bcd_to_bin_converter
    import bcd_pkg::*;
#(
    parameter int DIGITS    = 6,
    parameter int BIN_WIDTH = 20
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [DIGIT_W*DIGITS-1:0]  data_i,
    output logic [BIN_WIDTH-1:0]       data_o,
    output logic                       busy_o,
    output logic                       rdy_o,
    output logic                       err_o
);

    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int SR_W  = BCD_W + BIN_WIDTH;
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);

    // The largest BCD input must be representable in the binary result.
    if ((64'(10) ** DIGITS) > (64'(1) << BIN_WIDTH)) begin : g_cfg_check
        $error("bcd_to_bin_converter: 10**DIGITS exceeds 2**BIN_WIDTH");
    end

    conv_state_e          state_q, state_d;
    logic [SR_W-1:0]      sr_q, sr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIN_WIDTH-1:0] data_q, data_d;
    logic                 busy_q, busy_d;
    logic                 rdy_q, rdy_d;
    logic                 err_q, err_d;
    logic                 bad_q, bad_d;
    logic                 start_bad;

    logic [SR_W-1:0]      sr_shift;
    logic [SR_W-1:0]      sr_corr;

    assign sr_shift = sr_q >> 1;
    assign sr_corr[BIN_WIDTH-1:0] = sr_shift[BIN_WIDTH-1:0];

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_corr
        bcd_digit_corr u_corr (
            .nib_i (sr_shift[BIN_WIDTH + gi*DIGIT_W +: DIGIT_W]),
            .nib_o (sr_corr [BIN_WIDTH + gi*DIGIT_W +: DIGIT_W])
        );
    end

`ifdef BCD2BIN_DIGIT_CHECK_EN
    logic [DIGITS-1:0] nib_bad;
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_chk
        assign nib_bad[gi] = !nibble_is_bcd(data_i[gi*DIGIT_W +: DIGIT_W]);
    end
    assign start_bad = |nib_bad;
`else
    assign start_bad = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        busy_d  = busy_q;
        rdy_d   = 1'b0;
        err_d   = err_q;
        bad_d   = bad_q;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    sr_d    = {data_i, {BIN_WIDTH{1'b0}}};
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    bad_d   = start_bad;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sr_d  = sr_corr;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BIN_WIDTH - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Invalid input still runs the full schedule so timing is data-independent.
                data_d  = bad_q ? '0 : sr_q[BIN_WIDTH-1:0];
                err_d   = bad_q;
                rdy_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
            bad_q   <= bad_d;
        end
    end

    assign data_o = data_q;
    assign busy_o = busy_q;
    assign rdy_o  = rdy_q;
    assign err_o  = err_q;

endmodule
